// File: rtl/perceptron_trainer.sv
// Perceptron training sequencer: holds the training set and the weight/bias
// registers, presents samples to the perceptron and applies the learning rule.
module perceptron_trainer #(
    parameter int SIZE = 2,
    parameter int NUM  = 4,
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int EPW  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(NUM)-1:0]   wr_addr,
    input  logic [SIZE*DW-1:0]       wr_sample,
    input  logic [DW-1:0]            wr_expected,
    input  logic                     start,
    input  logic [EPW-1:0]           epochs,
    input  logic [3:0]               lr_shift,
    output logic [SIZE*DW-1:0]       x_out,
    output logic                     x_valid,
    input  logic                     x_ready,
    input  logic [DW-1:0]            pred_in,
    input  logic                     pred_valid,
    output logic [SIZE*DW-1:0]       weights,
    output logic [DW-1:0]            bias,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NUM+1)-1:0] err_count
);

    localparam int AW = $clog2(NUM);
    localparam int CW = $clog2(NUM+1);
    localparam int PW = 2*DW + 1;

    localparam logic signed [PW:0] SAT_HI = {{(PW+2-DW){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW:0] SAT_LO = {{(PW+2-DW){1'b1}}, {(DW-1){1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [SIZE*DW-1:0] mem_x [NUM];
    logic [DW-1:0]      mem_e [NUM];

    logic [2:0]         state;
    logic [AW-1:0]      idx;
    logic [EPW-1:0]     ep;
    logic [EPW-1:0]     epochs_q;
    logic [3:0]         lr_q;
    logic [CW-1:0]      ep_err;
    logic signed [DW:0] err_q;
    logic [SIZE*DW-1:0] x_cur;
    logic [DW-1:0]      e_cur;
    logic [SIZE*DW-1:0] w_next;
    logic [DW-1:0]      b_next;

    // Clamp a wide intermediate to the signed DW range instead of wrapping.
    function automatic logic [DW-1:0] sat(input logic signed [PW:0] v);
        if (v > SAT_HI) return SAT_HI[DW-1:0];
        if (v < SAT_LO) return SAT_LO[DW-1:0];
        return v[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] upd_weight(input logic [DW-1:0] w,
                                                 input logic signed [DW:0] e,
                                                 input logic [DW-1:0] x,
                                                 input logic [3:0] lr);
        logic signed [PW-1:0] ea;
        logic signed [PW-1:0] xa;
        logic signed [PW-1:0] step;
        logic [PW:0]          sum;
        ea   = PW'(e);
        xa   = PW'($signed(x));
        step = (ea * xa) >>> (FRAC + int'(lr));
        sum  = {step[PW-1], step} + {{(PW+1-DW){w[DW-1]}}, w};
        return sat(sum);
    endfunction

    function automatic logic [DW-1:0] upd_bias(input logic [DW-1:0] b,
                                               input logic signed [DW:0] e,
                                               input logic [3:0] lr);
        logic signed [DW:0] step;
        logic [PW:0]        sum;
        step = e >>> lr;
        sum  = {{(PW-DW){step[DW]}}, step} + {{(PW+1-DW){b[DW-1]}}, b};
        return sat(sum);
    endfunction

    // NOTE: the sample memory has no reset; it is plain storage and a reset would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem_x[wr_addr] <= wr_sample;
            mem_e[wr_addr] <= wr_expected;
        end
    end

    assign x_cur = mem_x[idx];
    assign e_cur = mem_e[idx];
    assign x_out = x_cur;

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        w_next = weights;
        b_next = bias;
        for (int j = 0; j < SIZE; j++) begin
            w_next[j*DW +: DW] = upd_weight(weights[j*DW +: DW], err_q, x_cur[j*DW +: DW], lr_q);
        end
        b_next = upd_bias(bias, err_q, lr_q);
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            ep        <= '0;
            epochs_q  <= '0;
            lr_q      <= '0;
            ep_err    <= '0;
            err_q     <= '0;
            weights   <= '0;
            bias      <= '0;
            x_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (epochs != '0) begin
                            epochs_q <= epochs;
                            lr_q     <= lr_shift;
                            idx      <= '0;
                            ep       <= '0;
                            ep_err   <= '0;
                            busy     <= 1'b1;
                            x_valid  <= 1'b1;
                            state    <= S_ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (x_ready) begin
                        x_valid <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pred_valid) begin
                        err_q <= {e_cur[DW-1], e_cur} - {pred_in[DW-1], pred_in};
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    weights <= w_next;
                    bias    <= b_next;
                    if (err_q != '0) ep_err <= ep_err + CW'(1);
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx != AW'(NUM-1)) begin
                        idx     <= idx + AW'(1);
                        x_valid <= 1'b1;
                        state   <= S_ISSUE;
                    end else begin
                        err_count <= ep_err;
                        ep        <= ep + EPW'(1);
                        idx       <= '0;
                        ep_err    <= '0;
                        // Stop on a clean epoch or when the epoch budget is spent.
                        if (ep_err == '0 || (ep + EPW'(1)) == epochs_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            x_valid <= 1'b1;
                            state   <= S_ISSUE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: a plain-arithmetic training model
// predicts every issued sample and final result; a monitor compares.
module tb_perceptron_trainer;

    localparam int SIZE = 2;
    localparam int NUM  = 4;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int EPW  = 16;
    localparam int AW   = $clog2(NUM);
    localparam int CW   = $clog2(NUM+1);

    logic               clk, rst_n, wr_en, start, x_valid, x_ready, pred_valid, busy, done;
    logic [AW-1:0]      wr_addr;
    logic [SIZE*DW-1:0] wr_sample, x_out, weights;
    logic [DW-1:0]      wr_expected, pred_in, bias;
    logic [EPW-1:0]     epochs;
    logic [3:0]         lr_shift;
    logic [CW-1:0]      err_count;

    perceptron_trainer #(.SIZE(SIZE), .NUM(NUM), .DW(DW), .FRAC(FRAC), .EPW(EPW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sample(wr_sample),
        .wr_expected(wr_expected), .start(start), .epochs(epochs), .lr_shift(lr_shift),
        .x_out(x_out), .x_valid(x_valid), .x_ready(x_ready), .pred_in(pred_in),
        .pred_valid(pred_valid), .weights(weights), .bias(bias), .busy(busy), .done(done),
        .err_count(err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [SIZE*DW-1:0] x; logic [SIZE*DW-1:0] w; logic [DW-1:0] b; } issue_t;
    typedef struct { logic [SIZE*DW-1:0] w; logic [DW-1:0] b; logic [CW-1:0] ec; } fin_t;

    issue_t        xq[$];
    fin_t          dq[$];
    logic [DW-1:0] pq[$];

    int total = 0;
    int bad   = 0;

    // Training model state.
    int mx[NUM][SIZE];
    int me[NUM];
    int mw[SIZE];
    int mb;
    int mec;
    int const_pred;

    // Perceptron-stage emulation knobs.
    int ready_mode   = 1;
    int pred_dly_max = 3;
    bit spur_always  = 1'b0;
    bit stall_pred   = 1'b0;
    int done_cnt     = 0;
    int hs_cnt       = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [SIZE*DW-1:0] pack_w();
        logic [SIZE*DW-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*DW +: DW] = DW'(mw[j]);
        return r;
    endfunction

    function automatic logic [SIZE*DW-1:0] pack_x(input int i);
        logic [SIZE*DW-1:0] r;
        for (int j = 0; j < SIZE; j++) r[j*DW +: DW] = DW'(mx[i][j]);
        return r;
    endfunction

    // Step activation: output 1.0 when the weighted sum plus bias is positive.
    function automatic int step_pred(input longint w0, input longint w1, input longint b, input int i);
        longint acc;
        acc = ((w0 * mx[i][0] + w1 * mx[i][1]) >>> FRAC) + b;
        return (acc > 0) ? 256 : 0;
    endfunction

    // Plays the whole training run in the model; mode 0 constant, 1 step, 2 random prediction.
    task automatic plan(input int ep_max, input int lr, input int mode, output int samples);
        int errs, pred, err;
        samples = 0;
        for (int ep = 0; ep < ep_max; ep++) begin
            errs = 0;
            for (int i = 0; i < NUM; i++) begin
                xq.push_back('{x: pack_x(i), w: pack_w(), b: DW'(mb)});
                if (mode == 0)      pred = const_pred;
                else if (mode == 1) pred = step_pred(mw[0], mw[1], mb, i);
                else if ($urandom_range(0, 3) == 0) pred = me[i];
                else pred = int'($urandom_range(0, 65535)) - 32768;
                pq.push_back(DW'(pred));
                err = me[i] - pred;
                if (err != 0) errs++;
                for (int j = 0; j < SIZE; j++)
                    mw[j] = sat16(longint'(mw[j]) + ((longint'(err) * mx[i][j]) >>> (FRAC + lr)));
                mb = sat16(longint'(mb) + (err >>> lr));
                samples++;
            end
            mec = errs;
            if (errs == 0) break;
        end
        dq.push_back('{w: pack_w(), b: DW'(mb), ec: CW'(mec)});
    endtask

    task automatic set_sample(input int i, input int x0, input int x1, input int e);
        mx[i][0] = x0;
        mx[i][1] = x1;
        me[i]    = e;
        @(negedge clk);
        wr_en       = 1'b1;
        wr_addr     = AW'(i);
        wr_sample   = pack_x(i);
        wr_expected = DW'(e);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    function automatic int rnd_val();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 1024)) - 512;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic run_start(input int ep, input int lr, input int mode, output int samples);
        @(negedge clk);
        plan(ep, lr, mode, samples);
        start    = 1'b1;
        epochs   = EPW'(ep);
        lr_shift = 4'(lr);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int cycles);
        int s;
        s = done_cnt;
        cycles = 0;
        while (done_cnt == s && cycles < 4000) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        check({name, "_done_seen"}, 64'(done_cnt != s), 64'd1);
    endtask

    // Perceptron stage: accepts samples, returns the planned prediction after a delay,
    // and throws stray pred_valid pulses while a sample is waiting for x_ready.
    initial begin : responder
        int pend;
        pend       = 0;
        x_ready    = 1'b0;
        pred_valid = 1'b0;
        pred_in    = '0;
        forever begin
            @(negedge clk);
            pred_valid = 1'b0;
            if (!rst_n) begin
                pend    = 0;
                x_ready = 1'b0;
            end else begin
                if (pend > 0 && !stall_pred) begin
                    pend--;
                    if (pend == 0) begin
                        pred_valid = 1'b1;
                        pred_in    = (pq.size() > 0) ? pq.pop_front() : '0;
                    end
                end
                if (ready_mode == 0)      x_ready = 1'b0;
                else if (ready_mode == 2) x_ready = 1'b1;
                else                      x_ready = ($urandom_range(0, 2) != 0);
                if (pend == 0 && !pred_valid && x_valid) begin
                    if (x_ready) pend = 1 + int'($urandom_range(0, pred_dly_max));
                    else if (spur_always || $urandom_range(0, 3) == 0) begin
                        pred_valid = 1'b1;
                        pred_in    = DW'($urandom);
                    end
                end
            end
        end
    end

    initial begin : monitor
        fin_t f;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (x_valid) begin
                    if (xq.size() == 0) check("x_valid_unexpected", 64'(x_valid), 64'd0);
                    else begin
                        check("x_out", 64'(x_out), 64'(xq[0].x));
                        if (x_ready) begin
                            check("w_at_issue", 64'(weights), 64'(xq[0].w));
                            check("b_at_issue", 64'(bias), 64'(xq[0].b));
                            xq.delete(0);
                            hs_cnt++;
                        end
                    end
                end
                if (done) begin
                    if (dq.size() == 0) check("done_unexpected", 64'(done), 64'd0);
                    else begin
                        f = dq.pop_front();
                        check("w_final", 64'(weights), 64'(f.w));
                        check("b_final", 64'(bias), 64'(f.b));
                        check("err_count", 64'(err_count), 64'(f.ec));
                        check("busy_at_done", 64'(busy), 64'd0);
                        check("samples_left", 64'(xq.size()), 64'd0);
                    end
                    done_cnt++;
                end
            end
        end
    end

    initial begin : stimulus
        int n, c, d0, hs0;
        logic [SIZE*DW-1:0] x0;
        longint dw0, dw1, dbv;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_sample = '0; wr_expected = '0;
        start = 1'b0; epochs = '0; lr_shift = '0;
        mw = '{0, 0}; mb = 0; mec = 0; const_pred = 0;
        #2;
        check("rst_weights", 64'(weights), 64'd0);
        check("rst_bias", 64'(bias), 64'd0);
        check("rst_busy_xv_done", 64'({busy, x_valid, done}), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        #20 rst_n = 1'b1;

        // Single update from zero weights.
        set_sample(0, 'h0100, 'h0080, 'h0100);
        for (int i = 1; i < NUM; i++) set_sample(i, 0, 0, 0);
        const_pred = 0;
        run_start(1, 1, 0, n);
        wait_done("single", c);
        check("single_w", 64'(weights), 64'h0040_0080);
        check("single_b", 64'(bias), 64'h0080);
        check("single_ec", 64'(err_count), 64'd1);
        @(negedge clk); #1;
        check("done_one_cycle", 64'(done), 64'd0);

        // Zero-epoch start: done pulse, busy never rises.
        d0 = done_cnt;
        run_start(0, 3, 0, n);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #2;
            check("ep0_busy", 64'(busy), 64'd0);
        end
        check("ep0_done_count", 64'(done_cnt - d0), 64'd1);

        // Randomised runs; one pokes start and wr_en while busy.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM; i++) set_sample(i, rnd_val(), rnd_val(), rnd_val());
            run_start((r == 1) ? 3 : int'($urandom_range(1, 3)), int'($urandom_range(0, 5)), 2, n);
            if (r == 1) begin
                repeat (3) @(negedge clk);
                check("busy_before_poke", 64'(busy), 64'd1);
                start = 1'b1; epochs = '0; wr_en = 1'b1; wr_addr = '0;
                wr_sample = {SIZE{16'h5a5a}}; wr_expected = 16'h1234;
                @(negedge clk);
                start = 1'b0; wr_en = 1'b0;
            end
            wait_done("random", c);
        end

        // Saturation: huge error drives weights and bias to the positive rail.
        for (int i = 0; i < NUM; i++) set_sample(i, 'h7fff, 'h7fff, 'h7fff);
        const_pred = -32768;
        run_start(4, 0, 0, n);
        wait_done("sat", c);
        check("sat_w", 64'(weights), 64'h7fff_7fff);
        check("sat_b", 64'(bias), 64'h7fff);

        // Back-pressure: x_ready held low while stray predictions arrive.
        for (int i = 0; i < NUM; i++) set_sample(i, rnd_val(), rnd_val(), rnd_val());
        ready_mode = 0; spur_always = 1'b1;
        run_start(1, 2, 2, n);
        c = 0;
        while (!x_valid && c < 20) begin @(negedge clk); #2; c++; end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #2;
            check("hold_x_valid", 64'(x_valid), 64'd1);
            check("hold_x_out", 64'(x_out), 64'(pack_x(0)));
        end
        spur_always = 1'b0; ready_mode = 1;
        wait_done("handshake", c);

        // Reset while waiting for a prediction.
        for (int i = 0; i < NUM; i++) set_sample(i, rnd_val(), rnd_val(), rnd_val());
        run_start(3, 1, 2, n);
        hs0 = hs_cnt; c = 0;
        while (hs_cnt < hs0 + 2 && c < 200) begin @(negedge clk); c++; end
        stall_pred = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 64'd1);
        check("pre_rst_x_valid", 64'(x_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_weights", 64'(weights), 64'd0);
        check("midrst_bias", 64'(bias), 64'd0);
        check("midrst_busy_xv", 64'({busy, x_valid}), 64'd0);
        xq.delete(); dq.delete(); pq.delete();
        mw = '{0, 0}; mb = 0; mec = 0;
        stall_pred = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;

        // AND gate at minimum latency.
        set_sample(0, 0, 0, 0);
        set_sample(1, 0, 'h0100, 0);
        set_sample(2, 'h0100, 0, 0);
        set_sample(3, 'h0100, 'h0100, 'h0100);
        ready_mode = 2; pred_dly_max = 0;
        run_start(20, 2, 1, n);
        wait_done("and", c);
        check("and_latency", 64'(c), 64'(4 * n));
        check("and_early", 64'(c < 4 * NUM * 20), 64'd1);
        check("and_err_count", 64'(err_count), 64'd0);
        dw0 = longint'($signed(weights[DW-1:0]));
        dw1 = longint'($signed(weights[2*DW-1:DW]));
        dbv = longint'($signed(bias));
        for (int i = 0; i < NUM; i++) check("and_classify", 64'(step_pred(dw0, dw1, dbv, i)), 64'(me[i]));
        ready_mode = 1; pred_dly_max = 3;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
